// File: rtl/mem_bus_if_pkg.sv
// Shared definitions for the MEM-stage bus master sequencer.
//   - FSM state encoding (2 bits)
//   - bus direction values (READ/WRITE)
//   - active-low enable/disable levels used on the bus control lines
//   - word address and data widths
package mem_bus_if_pkg;

    localparam int WORD_ADDR_W = 30;
    localparam int DATA_W      = 32;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    // Active-low control levels for as_, bus_req_, bus_grnt_, bus_as_, bus_rdy_
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef enum logic [1:0] {
        BUS_IF_STATE_IDLE   = 2'd0,
        BUS_IF_STATE_REQ    = 2'd1,
        BUS_IF_STATE_ACCESS = 2'd2,
        BUS_IF_STATE_STALL  = 2'd3
    } bus_if_state_e;

endpackage

// File: rtl/mem_bus_if_timeout_cnt.sv
// Ready-timeout counter for the bus master.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   clear       - zero the count (takes priority over enable)
//   enable      - increment the count this cycle
//   terminal    - count currently equals TIMEOUT_CYC
module mem_bus_if_timeout_cnt #(
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign terminal = (count_reg == CNT_W'(TIMEOUT_CYC));

endmodule

// File: rtl/mem_bus_if.sv
// Bus master sequencer between the MEM-stage access controller and the
// shared system bus. A single-cycle access strobe starts a multi-cycle
// transaction: request -> grant -> one-cycle address strobe -> wait ready.
// A watchdog aborts the transaction if ready never arrives.
// Ports:
//   clk, reset               - clock, synchronous active-high reset
//   stall, flush             - pipeline control
//   as_, rw, addr, wr_data   - access request from MEM stage (as_ active low)
//   rd_data                  - read buffer, updated only by completed reads
//   busy                     - pipeline stall request (combinational)
//   bus_err                  - one-cycle pulse after a timeout abort
//   bus_req_/bus_grnt_       - bus arbitration (active low)
//   bus_as_/bus_rw/bus_addr/bus_wr_data/bus_rd_data/bus_rdy_ - bus signals
module mem_bus_if
    import mem_bus_if_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   as_,
    input  logic                   rw,
    input  logic [WORD_ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]      wr_data,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   busy,
    output logic                   bus_err,
    output logic                   bus_req_,
    input  logic                   bus_grnt_,
    output logic                   bus_as_,
    output logic                   bus_rw,
    output logic [WORD_ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0]      bus_wr_data,
    input  logic [DATA_W-1:0]      bus_rd_data,
    input  logic                   bus_rdy_
);

    bus_if_state_e          state_reg;
    logic                   bus_req_reg;
    logic                   bus_as_reg;
    logic                   bus_rw_reg;
    logic [WORD_ADDR_W-1:0] bus_addr_reg;
    logic [DATA_W-1:0]      bus_wr_data_reg;
    logic [DATA_W-1:0]      rd_buf_reg;
    logic                   bus_err_reg;
    logic                   timeout_tc;

    // Counter is zeroed while waiting for grant so every ACCESS starts at 0,
    // and counts only the cycles in ACCESS that ready is still high.
    mem_bus_if_timeout_cnt #(
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear    (state_reg == BUS_IF_STATE_REQ),
        .enable   ((state_reg == BUS_IF_STATE_ACCESS) && (bus_rdy_ == DISABLE_)),
        .terminal (timeout_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= BUS_IF_STATE_IDLE;
            bus_req_reg     <= DISABLE_;
            bus_as_reg      <= DISABLE_;
            bus_rw_reg      <= READ;
            bus_addr_reg    <= '0;
            bus_wr_data_reg <= '0;
            rd_buf_reg      <= '0;
            bus_err_reg     <= 1'b0;
        end else begin
            // Address strobe and error are single-cycle pulses.
            bus_as_reg  <= DISABLE_;
            bus_err_reg <= 1'b0;
            case (state_reg)
                BUS_IF_STATE_IDLE: begin
                    if ((as_ == ENABLE_) && !flush) begin
                        bus_addr_reg    <= addr;
                        bus_rw_reg      <= rw;
                        bus_wr_data_reg <= wr_data;
                        bus_req_reg     <= ENABLE_;
                        state_reg       <= BUS_IF_STATE_REQ;
                    end
                end
                BUS_IF_STATE_REQ: begin
                    if (bus_grnt_ == ENABLE_) begin
                        bus_as_reg <= ENABLE_;
                        state_reg  <= BUS_IF_STATE_ACCESS;
                    end
                end
                BUS_IF_STATE_ACCESS: begin
                    // Ready takes precedence over a coincident timeout.
                    if (bus_rdy_ == ENABLE_) begin
                        if (bus_rw_reg == READ) begin
                            rd_buf_reg <= bus_rd_data;
                        end
                        bus_req_reg <= DISABLE_;
                        state_reg   <= stall ? BUS_IF_STATE_STALL : BUS_IF_STATE_IDLE;
                    end else if (timeout_tc) begin
                        bus_req_reg <= DISABLE_;
                        bus_err_reg <= 1'b1;
                        state_reg   <= BUS_IF_STATE_IDLE;
                    end
                end
                BUS_IF_STATE_STALL: begin
                    // as_ is ignored here: the same instruction is still presented.
                    if (!stall || flush) begin
                        state_reg <= BUS_IF_STATE_IDLE;
                    end
                end
                default: state_reg <= BUS_IF_STATE_IDLE;
            endcase
        end
    end

    // busy must be combinational so the pipeline stalls in the very cycle
    // the access is presented and releases in the very cycle ready arrives.
    always_comb begin
        busy = 1'b0;
        case (state_reg)
            BUS_IF_STATE_IDLE:   busy = (as_ == ENABLE_) && !flush;
            BUS_IF_STATE_REQ:    busy = 1'b1;
            BUS_IF_STATE_ACCESS: busy = (bus_rdy_ == DISABLE_);
            BUS_IF_STATE_STALL:  busy = 1'b0;
            default:             busy = 1'b0;
        endcase
    end

    assign rd_data     = rd_buf_reg;
    assign bus_err     = bus_err_reg;
    assign bus_req_    = bus_req_reg;
    assign bus_as_     = bus_as_reg;
    assign bus_rw      = bus_rw_reg;
    assign bus_addr    = bus_addr_reg;
    assign bus_wr_data = bus_wr_data_reg;

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed testbench for mem_bus_if (TIMEOUT_CYC = 4).
// Inputs change 1 time unit after the rising edge; outputs are sampled
// 4 time units after the rising edge, before the next edge.
module tb_mem_bus_if;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        as_;
    logic        rw;
    logic [29:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        busy;
    logic        bus_err;
    logic        bus_req_;
    logic        bus_grnt_;
    logic        bus_as_;
    logic        bus_rw;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_rd_data;
    logic        bus_rdy_;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_bus_if #(
        .TIMEOUT_CYC (4),
        .CNT_W       (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .as_         (as_),
        .rw          (rw),
        .addr        (addr),
        .wr_data     (wr_data),
        .rd_data     (rd_data),
        .busy        (busy),
        .bus_err     (bus_err),
        .bus_req_    (bus_req_),
        .bus_grnt_   (bus_grnt_),
        .bus_as_     (bus_as_),
        .bus_rw      (bus_rw),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .bus_rd_data (bus_rd_data),
        .bus_rdy_    (bus_rdy_)
    );

    task automatic idle_inputs();
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        as_ = 1'b1; rw = 1'b1; addr = '0; wr_data = '0;
        bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        #3;
        checks++; if (bus_req_ !== 1'b1) begin errors++; $display("FAIL reset_bus_req_: got %b want 1", bus_req_); end
        checks++; if (bus_as_ !== 1'b1) begin errors++; $display("FAIL reset_bus_as_: got %b want 1", bus_as_); end
        checks++; if (bus_rw !== 1'b1) begin errors++; $display("FAIL reset_bus_rw: got %b want 1", bus_rw); end
        checks++; if (bus_addr !== 30'h0) begin errors++; $display("FAIL reset_bus_addr: got %h want 0", bus_addr); end
        checks++; if (bus_wr_data !== 32'h0) begin errors++; $display("FAIL reset_bus_wr_data: got %h want 0", bus_wr_data); end
        checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        next_cycle();
        $display("txn reset done");
    endtask

    task automatic test_read_immediate();
        int busy_cnt = 0;
        int as_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            as_ = (i == 0) ? 1'b0 : 1'b1;
            addr = (i == 0) ? 30'h100 : 30'h0;
            bus_grnt_ = 1'b0; bus_rdy_ = 1'b0; bus_rd_data = 32'hDEADBEEF;
            #3;
            if (busy === 1'b1) busy_cnt++;
            if (bus_as_ === 1'b0) as_cnt++;
            if (i == 1) begin
                checks++; if (bus_addr !== 30'h100) begin errors++; $display("FAIL rdimm_bus_addr: got %h want 100", bus_addr); end
                checks++; if (bus_req_ !== 1'b0) begin errors++; $display("FAIL rdimm_bus_req_: got %b want 0", bus_req_); end
            end
            if (i == 2) begin
                checks++; if (bus_as_ !== 1'b0) begin errors++; $display("FAIL rdimm_as_at_2: got %b want 0", bus_as_); end
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rdimm_busy_at_2: got %b want 0", busy); end
            end
            next_cycle();
        end
        checks++; if (busy_cnt != 2) begin errors++; $display("FAIL rdimm_busy_cycles: got %0d want 2", busy_cnt); end
        checks++; if (as_cnt != 1) begin errors++; $display("FAIL rdimm_as_cycles: got %0d want 1", as_cnt); end
        checks++; if (rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL rdimm_rd_data: got %h want deadbeef", rd_data); end
        $display("txn read addr=100 rd_data=%h", rd_data);
    endtask

    task automatic test_write_delayed();
        int req_cnt = 0;
        int as_cnt = 0;
        int unstable = 0;
        for (int i = 0; i < 9; i++) begin
            idle_inputs();
            if (i == 0) begin
                as_ = 1'b0; rw = 1'b0; addr = 30'h3; wr_data = 32'h12345678;
            end
            bus_grnt_ = (i == 3) ? 1'b0 : 1'b1;
            bus_rdy_ = (i == 6) ? 1'b0 : 1'b1;
            bus_rd_data = 32'hFFFF0000;
            #3;
            if (bus_req_ === 1'b0) req_cnt++;
            if (bus_as_ === 1'b0) as_cnt++;
            if (i >= 1 && i <= 6) begin
                if (bus_rw !== 1'b0 || bus_wr_data !== 32'h12345678 || bus_addr !== 30'h3) unstable++;
            end
            if (i == 6) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_busy_at_ready: got %b want 0", busy); end
            end
            next_cycle();
        end
        checks++; if (req_cnt != 6) begin errors++; $display("FAIL wr_req_cycles: got %0d want 6", req_cnt); end
        checks++; if (as_cnt != 1) begin errors++; $display("FAIL wr_as_cycles: got %0d want 1", as_cnt); end
        checks++; if (unstable != 0) begin errors++; $display("FAIL wr_bus_fields_stable: got %0d bad cycles want 0", unstable); end
        checks++; if (rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_data: got %h want deadbeef", rd_data); end
        $display("txn write addr=3 data=12345678 req_cycles=%0d", req_cnt);
    endtask

    task automatic test_timeout();
        int req_cnt = 0;
        int err_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            as_ = (i == 0) ? 1'b0 : 1'b1;
            addr = 30'h7;
            bus_grnt_ = 1'b0; bus_rdy_ = 1'b1; bus_rd_data = 32'h0BAD0BAD;
            #3;
            if (bus_req_ === 1'b0) req_cnt++;
            if (bus_err === 1'b1) err_cnt++;
            if (i == 6) begin
                checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_busy_abort_cycle: got %b want 1", busy); end
            end
            if (i == 7) begin
                checks++; if (bus_err !== 1'b1) begin errors++; $display("FAIL to_bus_err_at_7: got %b want 1", bus_err); end
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy_after: got %b want 0", busy); end
                checks++; if (bus_req_ !== 1'b1) begin errors++; $display("FAIL to_bus_req_released: got %b want 1", bus_req_); end
            end
            next_cycle();
        end
        checks++; if (err_cnt != 1) begin errors++; $display("FAIL to_err_pulses: got %0d want 1", err_cnt); end
        checks++; if (req_cnt != 6) begin errors++; $display("FAIL to_req_cycles: got %0d want 6", req_cnt); end
        checks++; if (rd_data !== 32'hDEADBEEF) begin errors++; $display("FAIL to_rd_data: got %h want deadbeef", rd_data); end
        $display("txn read addr=7 timeout err_pulses=%0d", err_cnt);
    endtask

    task automatic test_ready_at_timeout();
        int err_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            idle_inputs();
            as_ = (i == 0) ? 1'b0 : 1'b1;
            addr = 30'h8;
            bus_grnt_ = 1'b0;
            bus_rdy_ = (i == 6) ? 1'b0 : 1'b1;
            bus_rd_data = 32'h0BADF00D;
            #3;
            if (bus_err === 1'b1) err_cnt++;
            if (i == 6) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rto_busy_at_ready: got %b want 0", busy); end
            end
            next_cycle();
        end
        checks++; if (err_cnt != 0) begin errors++; $display("FAIL rto_err_pulses: got %0d want 0", err_cnt); end
        checks++; if (rd_data !== 32'h0BADF00D) begin errors++; $display("FAIL rto_rd_data: got %h want 0badf00d", rd_data); end
        $display("txn read addr=8 ready on timeout cycle rd_data=%h", rd_data);
    endtask

    task automatic test_stall();
        int bad = 0;
        for (int i = 0; i <= 10; i++) begin
            idle_inputs();
            as_ = (i <= 4 || i == 7) ? 1'b0 : 1'b1;
            addr = 30'h20;
            stall = (i >= 2 && i <= 4);
            bus_grnt_ = 1'b0; bus_rdy_ = 1'b0;
            bus_rd_data = (i < 7) ? 32'hA5A5A5A5 : 32'h11111111;
            #3;
            if (i >= 3 && i <= 5) begin
                if (busy !== 1'b0 || bus_req_ !== 1'b1 || rd_data !== 32'hA5A5A5A5) bad++;
            end
            if (i == 6) begin
                checks++; if (bus_req_ !== 1'b1) begin errors++; $display("FAIL st_idle_req_: got %b want 1", bus_req_); end
            end
            if (i == 8) begin
                checks++; if (bus_req_ !== 1'b0) begin errors++; $display("FAIL st_new_req_from_idle: got %b want 0", bus_req_); end
            end
            if (i == 10) begin
                checks++; if (rd_data !== 32'h11111111) begin errors++; $display("FAIL st_second_read: got %h want 11111111", rd_data); end
            end
            next_cycle();
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL st_hold_in_stall: got %0d bad cycles want 0", bad); end
        $display("txn read addr=20 with stall, then read rd_data=%h", rd_data);
    endtask

    task automatic test_flush();
        int req_cnt = 0;
        int err_cnt = 0;
        // Flush in IDLE suppresses the access.
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            as_ = (i <= 1) ? 1'b0 : 1'b1;
            flush = (i <= 1);
            bus_grnt_ = 1'b0; bus_rdy_ = 1'b0;
            #3;
            if (i == 0) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fl_idle_busy: got %b want 0", busy); end
            end
            if (i >= 1) begin
                checks++; if (bus_req_ !== 1'b1) begin errors++; $display("FAIL fl_idle_no_req: got %b want 1", bus_req_); end
            end
            next_cycle();
        end
        // Flush during ACCESS does not cut the transaction short.
        for (int i = 0; i < 7; i++) begin
            idle_inputs();
            as_ = (i == 0) ? 1'b0 : 1'b1;
            addr = 30'h55;
            flush = (i >= 2 && i <= 4);
            bus_grnt_ = 1'b0;
            bus_rdy_ = (i == 4) ? 1'b0 : 1'b1;
            bus_rd_data = 32'hCAFEF00D;
            #3;
            if (bus_req_ === 1'b0) req_cnt++;
            if (bus_err === 1'b1) err_cnt++;
            next_cycle();
        end
        checks++; if (req_cnt != 4) begin errors++; $display("FAIL fl_access_req_cycles: got %0d want 4", req_cnt); end
        checks++; if (err_cnt != 0) begin errors++; $display("FAIL fl_access_err: got %0d want 0", err_cnt); end
        checks++; if (rd_data !== 32'hCAFEF00D) begin errors++; $display("FAIL fl_access_rd_data: got %h want cafef00d", rd_data); end
        // Flush in STALL returns to IDLE even while stall stays high.
        for (int i = 0; i < 9; i++) begin
            idle_inputs();
            as_ = (i == 0 || i == 5) ? 1'b0 : 1'b1;
            addr = 30'h66;
            stall = (i >= 2 && i <= 6);
            flush = (i == 3);
            bus_grnt_ = 1'b0; bus_rdy_ = 1'b0;
            bus_rd_data = 32'h22223333;
            #3;
            if (i == 6) begin
                checks++; if (bus_req_ !== 1'b0) begin errors++; $display("FAIL fl_stall_to_idle: got %b want 0", bus_req_); end
            end
            next_cycle();
        end
        $display("txn flush scenarios rd_data=%h", rd_data);
    endtask

    task automatic test_reset_in_access();
        for (int i = 0; i < 6; i++) begin
            idle_inputs();
            as_ = (i == 0) ? 1'b0 : 1'b1;
            addr = 30'h77;
            reset = (i == 3);
            bus_grnt_ = 1'b0; bus_rdy_ = 1'b1;
            #3;
            if (i == 3) begin
                checks++; if (bus_req_ !== 1'b0) begin errors++; $display("FAIL rst_acc_pre_req_: got %b want 0", bus_req_); end
            end
            if (i == 4) begin
                checks++; if (bus_req_ !== 1'b1) begin errors++; $display("FAIL rst_acc_req_: got %b want 1", bus_req_); end
                checks++; if (bus_as_ !== 1'b1) begin errors++; $display("FAIL rst_acc_as_: got %b want 1", bus_as_); end
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_acc_busy: got %b want 0", busy); end
                checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL rst_acc_rd_data: got %h want 0", rd_data); end
                checks++; if (bus_addr !== 30'h0) begin errors++; $display("FAIL rst_acc_bus_addr: got %h want 0", bus_addr); end
            end
            if (i == 5) begin
                checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rst_acc_bus_err: got %b want 0", bus_err); end
            end
            next_cycle();
        end
        $display("txn reset during access rd_data=%h", rd_data);
    endtask

    initial begin
        idle_inputs();
        next_cycle();
        test_reset();
        test_read_immediate();
        test_write_delayed();
        test_timeout();
        test_ready_at_timeout();
        test_stall();
        test_flush();
        test_reset_in_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
